// File: rtl/qaoa_kernel_prod_accum.sv
// Accumulates a stream of tagged multiplier products into an 80-bit sum and emits
// a shifted, saturated result with a term count through a one-entry output register.
module qaoa_kernel_prod_accum #(
    parameter int PROD_WIDTH = 76,
    parameter int ACC_WIDTH  = 80,
    parameter int OUT_WIDTH  = 48,
    parameter int FRAC_SHIFT = 28,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  issue_valid,
    input  logic                  issue_last,
    output logic                  issue_ready,
    output logic                  mul_ce,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat,
    output logic [15:0]           out_count
);

    localparam logic [ACC_WIDTH-1:0] FULL_SCALE =
        {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic [LATENCY-1:0]   tag_valid;
    logic [LATENCY-1:0]   tag_last;
    logic [ACC_WIDTH-1:0] acc;
    logic [15:0]          cnt;
    logic                 sticky;

    logic                 fin_valid;
    logic                 fin_last;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic [ACC_WIDTH-1:0] shifted;
    logic                 clamp;
    logic [OUT_WIDTH-1:0] res_data;
    logic [15:0]          cnt_inc;

    // Valid/ready: an issue is taken on a clk edge only when issue_valid and issue_ready
    // are both 1; a result leaves on an edge where out_valid and out_ready are both 1.
    // A pending unread result stalls the multiplier and the tag pipeline together.
    assign mul_ce      = ce & ~(out_valid & ~out_ready);
    assign issue_ready = mul_ce;

    assign fin_valid = tag_valid[LATENCY-1];
    assign fin_last  = tag_last[LATENCY-1];

    always_comb begin
        sum_wide = {1'b0, acc} + (ACC_WIDTH+1)'(prod);
        sum_ovf  = sum_wide[ACC_WIDTH];
        sum_sat  = sum_ovf ? '1 : sum_wide[ACC_WIDTH-1:0];
        shifted  = sum_sat >> FRAC_SHIFT;
        // Reaching full scale is reported as saturation, not only exceeding it.
        clamp    = (shifted >= FULL_SCALE);
        res_data = clamp ? '1 : shifted[OUT_WIDTH-1:0];
        cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            tag_last  <= '0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (mul_ce) begin
                for (int i = LATENCY - 1; i > 0; i--) begin
                    tag_valid[i] <= tag_valid[i-1];
                    tag_last[i]  <= tag_last[i-1];
                end
                tag_valid[0] <= issue_valid;
                tag_last[0]  <= issue_last;
                if (fin_valid) begin
                    if (fin_last) begin
                        acc       <= '0;
                        cnt       <= '0;
                        sticky    <= 1'b0;
                        out_data  <= res_data;
                        out_sat   <= sticky | sum_ovf | clamp;
                        out_count <= cnt_inc;
                        out_valid <= 1'b1;
                    end else begin
                        acc    <= sum_sat;
                        cnt    <= cnt_inc;
                        sticky <= sticky | sum_ovf;
                    end
                end
            end
        end
    end

endmodule
